// File: rtl/aes_frame_loader.sv
// aes_frame_loader: assembles header-framed key/message byte streams into
// parallel AES frames and holds each frame until downstream acknowledges it.
module aes_frame_loader #(
  parameter int unsigned nk       = 8,
  parameter int unsigned nb       = 4,
  parameter logic [7:0]  HDR_FULL = 8'hA5,
  parameter logic [7:0]  HDR_MSG  = 8'h5A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [32*nk-1:0] frame_key,
  output logic [32*nb-1:0] frame_msg,
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic             key_valid,
  output logic             hdr_err
);

  localparam int unsigned KW = 32 * nk;
  localparam int unsigned MW = 32 * nb;
  localparam int unsigned KB = 4 * nk;
  localparam int unsigned MB = 4 * nb;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    MSG  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [KW-1:0]   key_nxt;
  logic [MW-1:0]   msg_nxt;
  logic            key_valid_nxt;
  logic            hdr_err_nxt;
  logic            byte_ready_nxt;
  logic            frame_valid_nxt;
  logic            accept_c;

  // A byte is consumed only when the registered ready was high at the edge.
  assign accept_c = byte_valid && byte_ready;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    key_nxt       = frame_key;
    msg_nxt       = frame_msg;
    key_valid_nxt = key_valid;
    hdr_err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (accept_c) begin
          if (byte_in == HDR_FULL) begin
            state_nxt = KEY;
            cnt_nxt   = '0;
          end else if ((byte_in == HDR_MSG) && key_valid) begin
            state_nxt = MSG;
            cnt_nxt   = '0;
          end else begin
            hdr_err_nxt = 1'b1;
          end
        end
      end

      KEY: begin
        if (accept_c) begin
          key_nxt = {frame_key[KW-9:0], byte_in};
          if (cnt == CW'(KB - 1)) begin
            cnt_nxt       = '0;
            key_valid_nxt = 1'b1;
            state_nxt     = MSG;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end

      MSG: begin
        if (accept_c) begin
          msg_nxt = {frame_msg[MW-9:0], byte_in};
          if (cnt == CW'(MB - 1)) begin
            cnt_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end

      HOLD: begin
        if (frame_ack) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Handshake outputs follow the upcoming state so they are registered.
    byte_ready_nxt  = (state_nxt != HOLD);
    frame_valid_nxt = (state_nxt == HOLD);
  end

  // State, counter and registered outputs; reset aborts any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      frame_key   <= '0;
      frame_msg   <= '0;
      key_valid   <= 1'b0;
      hdr_err     <= 1'b0;
      byte_ready  <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      frame_key   <= key_nxt;
      frame_msg   <= msg_nxt;
      key_valid   <= key_valid_nxt;
      hdr_err     <= hdr_err_nxt;
      byte_ready  <= byte_ready_nxt;
      frame_valid <= frame_valid_nxt;
    end
  end

endmodule
